counter4b_checker: RTL and testbench
====================================

COUNTER4B_CHECKER -- requirements
Module: counter4b_checker

Interface
REQ-001 SHALL have parameter LOCK_LEN, default 4, meaning the number of consecutive correct increments needed to lock (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port sample_en  input  1  qualifies a sample of the counter outputs on this edge.
REQ-005 SHALL have ports Qa, Qb, Qc, Qd  input  1 each  observed count; Qa is the LSB and Qd the MSB.
REQ-006 SHALL have port Rc  input  1  observed ripple carry.
REQ-007 SHALL have port locked  output  1  high while the state is LOCK.
REQ-008 SHALL have port err_pulse  output  1  one-cycle pulse on each detected error.
REQ-009 SHALL have port rc_err  output  1  one-cycle pulse when Rc is inconsistent with the count.
REQ-010 SHALL have port err_cnt  output  8  saturating error count.
REQ-011 SHALL have port wrap_cnt  output  8  saturating count of 15->0 wraps seen while locked.
REQ-012 SHALL have port value  output  4  last sampled count {Qd,Qc,Qb,Qa}.

Function
REQ-013 SHALL implement states IDLE, ACQ, LOCK and ERR; Q denotes {Qd,Qc,Qb,Qa}; all outputs are registered.
REQ-014 SHALL do nothing in any state when sample_en=0, except that ERR advances to ACQ unconditionally on the next edge.
REQ-015 SHALL, in IDLE on a sample, load value<=Q, clear the run counter and move to ACQ.
REQ-016 SHALL, in ACQ on a sample, treat Q==(value+1) mod 16 as a match.
REQ-017 SHALL, in ACQ on a match, increment the run counter and enter LOCK when the run counter reaches LOCK_LEN.
REQ-018 SHALL, in ACQ on a mismatch, clear the run counter and stay in ACQ, with no err_pulse and no err_cnt change.
REQ-019 SHALL, in ACQ, load value<=Q on every sample.
REQ-020 SHALL, in LOCK on a match, stay in LOCK and load value<=Q.
REQ-021 SHALL, in LOCK when a match has value==15 and Q==0, increment wrap_cnt, saturating at 255.
REQ-022 SHALL, in LOCK on a mismatch, load value<=Q, assert err_pulse for the next cycle, increment err_cnt (saturating at 255) and enter ERR.
REQ-023 SHALL make ERR last exactly one clock, ignore any sample taken in ERR, then enter ACQ with the run counter cleared.
REQ-024 SHALL keep err_cnt at 255 on further errors and still pulse err_pulse.
REQ-025 SHALL treat a repeated value (Q==value) as a mismatch, i.e. a stalled counter is an error.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, run counter=0, value=0, locked=0, err_pulse=0, rc_err=0, err_cnt=0 and wrap_cnt=0 immediately, independent of clk.
REQ-027 SHALL, when reset is asserted mid-operation in any state, abandon that operation, and the first sample after reset release SHALL be handled as in IDLE.

Configuration
REQ-028 SHALL, when macro COUNTER4B_CHECKER_RC_CHECK_EN is defined, define an expected carry rc_exp = (Q==15) on each sample in ACQ or LOCK.
REQ-029 SHALL, with COUNTER4B_CHECKER_RC_CHECK_EN defined and Rc!=rc_exp, pulse rc_err for one cycle in either ACQ or LOCK.
REQ-030 SHALL, with COUNTER4B_CHECKER_RC_CHECK_EN defined and Rc!=rc_exp in ACQ, treat the sample as a mismatch.
REQ-031 SHALL, with COUNTER4B_CHECKER_RC_CHECK_EN defined and Rc!=rc_exp in LOCK, treat the sample as an error per REQ-022, incrementing err_cnt once even if the value also mismatches.
REQ-032 SHALL, when COUNTER4B_CHECKER_RC_CHECK_EN is undefined, ignore Rc, tie rc_err to 0 and keep all ports present.

Verification
REQ-033 SHALL cover: reset, then samples 3,4,5,6,7 with LOCK_LEN=4 -> locked=1 after the edge sampling 7; err_cnt=0.
REQ-034 SHALL cover: locked, then samples 14,15,0,1 with correct Rc -> wrap_cnt=1, no err_pulse, locked stays 1.
REQ-035 SHALL cover: locked at value 5, then sample 9 -> err_pulse for 1 cycle, err_cnt=1, ERR for 1 clock, then ACQ with value=9; relock after 4 further correct increments.
REQ-036 SHALL cover: with the macro defined, locked, sample Q=15 with Rc=0 -> rc_err=1, err_pulse=1, err_cnt+1; with the macro undefined, the same stimulus -> no error.
REQ-037 SHALL cover: rst_n driven low mid-LOCK between clock edges -> all outputs 0 immediately; after release, 256 forced errors -> err_cnt=255 held.
REQ-038 SHALL cover: sample_en toggled 1,0,0,1 with Q advancing only on enabled edges -> no error; held Q 6,6 on two enabled edges while locked -> error.

Source files
------------

// File: rtl/counter4b_checker.sv
// -----------------------------------------------------------------------------
// counter4b_checker
//
// Watches the outputs of a free-running 4-bit up counter and decides whether it
// is counting correctly. The checker first acquires the sequence (LOCK_LEN
// consecutive +1 steps), then stays locked while every sample is the previous
// one plus one (mod 16). Any break in the sequence while locked is an error:
// err_pulse fires for one cycle, err_cnt is bumped and the checker spends one
// clock in ERR before re-acquiring.
//
// Optional feature (macro COUNTER4B_CHECKER_RC_CHECK_EN):
//   when defined, the ripple-carry input Rc is also checked. It must be high
//   exactly when the sampled count is 15. A bad carry pulses rc_err and counts
//   as a sequence mismatch. When undefined, Rc is ignored and rc_err stays 0.
//
// Parameters:
//   LOCK_LEN   consecutive correct increments needed to lock (1..15)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sample_en  qualifies a sample of Qa..Qd / Rc on this edge
//   Qa..Qd     observed count, Qa = LSB, Qd = MSB
//   Rc         observed ripple carry
//   locked     high while in LOCK
//   err_pulse  one-cycle pulse per detected error while locked
//   rc_err     one-cycle pulse when Rc disagrees with the count
//   err_cnt    saturating (255) error count
//   wrap_cnt   saturating (255) count of 15->0 wraps seen while locked
//   value      last sampled count {Qd,Qc,Qb,Qa}
// -----------------------------------------------------------------------------
module counter4b_checker #(
    parameter int unsigned LOCK_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic       Qa,
    input  logic       Qb,
    input  logic       Qc,
    input  logic       Qd,
    input  logic       Rc,
    output logic       locked,
    output logic       err_pulse,
    output logic       rc_err,
    output logic [7:0] err_cnt,
    output logic [7:0] wrap_cnt,
    output logic [3:0] value
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_LOCK,
        ST_ERR
    } state_e;

    localparam logic [3:0] LOCK_LEN_W = 4'(LOCK_LEN);

    state_e     state_q,     state_d;
    logic [3:0] run_q,       run_d;
    logic [3:0] value_q,     value_d;
    logic       locked_q,    locked_d;
    logic       err_pulse_q, err_pulse_d;
    logic       rc_err_q,    rc_err_d;
    logic [7:0] err_cnt_q,   err_cnt_d;
    logic [7:0] wrap_cnt_q,  wrap_cnt_d;

    logic [3:0] q_obs;
    logic [3:0] value_inc;
    logic       rc_bad;
    logic       seq_ok;

    assign q_obs     = {Qd, Qc, Qb, Qa};
    assign value_inc = value_q + 4'd1;   // 4-bit add wraps 15 -> 0

`ifdef COUNTER4B_CHECKER_RC_CHECK_EN
    assign rc_bad = (Rc != (q_obs == 4'd15));
`else
    logic unused_rc;
    assign unused_rc = Rc;
    assign rc_bad    = 1'b0;
`endif

    // A bad carry spoils an otherwise correct step, so the rest of the FSM
    // only has to look at one "sequence ok" signal.
    assign seq_ok = (q_obs == value_inc) && !rc_bad;

    // NOTE: every always_comb target gets a default first so that no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        value_d     = value_q;
        err_cnt_d   = err_cnt_q;
        wrap_cnt_d  = wrap_cnt_q;
        err_pulse_d = 1'b0;
        rc_err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sample_en) begin
                    value_d = q_obs;
                    run_d   = 4'd0;
                    state_d = ST_ACQ;
                end
            end

            ST_ACQ: begin
                if (sample_en) begin
                    value_d  = q_obs;
                    rc_err_d = rc_bad;
                    if (seq_ok) begin
                        run_d = run_q + 4'd1;
                        if (run_q + 4'd1 == LOCK_LEN_W) begin
                            state_d = ST_LOCK;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
            end

            ST_LOCK: begin
                if (sample_en) begin
                    value_d  = q_obs;
                    rc_err_d = rc_bad;
                    if (seq_ok) begin
                        if (value_q == 4'd15 && wrap_cnt_q != 8'hFF) begin
                            wrap_cnt_d = wrap_cnt_q + 8'd1;
                        end
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        state_d = ST_ERR;
                    end
                end
            end

            ST_ERR: begin
                // Single recovery clock; any sample on this edge is discarded.
                run_d   = 4'd0;
                state_d = ST_ACQ;
            end

            default: state_d = ST_IDLE;
        endcase

        // Registered copy of "next state is LOCK" so locked tracks state_q.
        locked_d = (state_d == ST_LOCK);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            run_q       <= 4'd0;
            value_q     <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            rc_err_q    <= 1'b0;
            err_cnt_q   <= 8'd0;
            wrap_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            value_q     <= value_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            rc_err_q    <= rc_err_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign rc_err    = rc_err_q;
    assign err_cnt   = err_cnt_q;
    assign wrap_cnt  = wrap_cnt_q;
    assign value     = value_q;

endmodule

// File: tb/tb_counter4b_checker.sv
// -----------------------------------------------------------------------------
// tb_counter4b_checker
//
// Drives counter4b_checker with directed and randomized counter samples and
// compares every output against a sequence-level reference model kept here.
// -----------------------------------------------------------------------------
module tb_counter4b_checker;

    localparam int LOCK_LEN = 4;
`ifdef COUNTER4B_CHECKER_RC_CHECK_EN
    localparam bit RC_CHK = 1'b1;
`else
    localparam bit RC_CHK = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       sample_en;
    logic [3:0] q_drv;
    logic       Rc;
    logic       locked;
    logic       err_pulse;
    logic       rc_err;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic [3:0] value;

    int checks   = 0;
    int failures = 0;

    counter4b_checker #(.LOCK_LEN(LOCK_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .Qa        (q_drv[0]),
        .Qb        (q_drv[1]),
        .Qc        (q_drv[2]),
        .Qd        (q_drv[3]),
        .Rc        (Rc),
        .locked    (locked),
        .err_pulse (err_pulse),
        .rc_err    (rc_err),
        .err_cnt   (err_cnt),
        .wrap_cnt  (wrap_cnt),
        .value     (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (sequence-level) ----------------
    bit m_started;   // a first sample has been taken since reset
    bit m_locked;
    bit m_in_err;    // the next edge is the recovery clock
    int m_value;
    int m_run;       // consecutive good steps while acquiring
    int m_err;
    int m_wrap;
    bit e_err_pulse;
    bit e_rc_err;

    task automatic model_reset();
        m_started = 0; m_locked = 0; m_in_err = 0;
        m_value = 0; m_run = 0; m_err = 0; m_wrap = 0;
        e_err_pulse = 0; e_rc_err = 0;
    endtask

    task automatic model_step(input bit en, input int q, input bit rc);
        bit rc_bad;
        bit good;
        e_err_pulse = 0;
        e_rc_err    = 0;
        if (m_in_err) begin
            m_in_err = 0;
            m_run    = 0;
        end else if (en) begin
            if (!m_started) begin
                m_started = 1;
                m_run     = 0;
            end else begin
                rc_bad   = RC_CHK && (rc != (q == 15));
                good     = (q == (m_value + 1) % 16) && !rc_bad;
                e_rc_err = rc_bad;
                if (m_locked) begin
                    if (good) begin
                        if (m_value == 15 && q == 0 && m_wrap < 255) m_wrap++;
                    end else begin
                        e_err_pulse = 1;
                        if (m_err < 255) m_err++;
                        m_locked = 0;
                        m_in_err = 1;
                        m_run    = 0;
                    end
                end else begin
                    m_run = good ? m_run + 1 : 0;
                    if (m_run == LOCK_LEN) m_locked = 1;
                end
            end
            m_value = q;
        end
    endtask

    // Apply one edge of stimulus away from the clock edge, then step the model.
    task automatic drive(input bit en, input int q, input bit rc);
        @(negedge clk);
        sample_en = en;
        q_drv     = 4'(q);
        Rc        = rc;
        @(posedge clk);
        #1;
        model_step(en, q, rc);
    endtask

    // Feed correct increments until the model says locked (at target if >= 0).
    task automatic advance_to(input int target);
        int nq;
        bit done;
        done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (m_locked && (target < 0 || m_value == target)) begin
                done = 1;
            end else if (m_in_err) begin
                drive(0, 0, 0);
            end else begin
                nq = (m_value + 1) % 16;
                drive(1, nq, nq == 15);
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL advance_to timeout target=%0d got_value=%0d", target, m_value);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; sample_en = 1'b0; q_drv = 4'd0; Rc = 1'b0;
        model_reset();
        #3;
        checks++;
        if ({locked, err_pulse, rc_err, err_cnt, wrap_cnt, value} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {locked, err_pulse, rc_err, err_cnt, wrap_cnt, value});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lock_acquire();
        int seq [5] = '{3, 4, 5, 6, 7};
        for (int i = 0; i < 5; i++) begin
            drive(1, seq[i], 0);
            checks++;
            if (locked !== (i == 4)) begin
                failures++;
                $display("FAIL acquire_locked step=%0d got=%0b exp=%0b", i, locked, i == 4);
            end
        end
        checks++;
        if (err_cnt !== 8'd0 || value !== 4'd7) begin
            failures++;
            $display("FAIL acquire_state got err_cnt=%0d value=%0d exp err_cnt=0 value=7",
                     err_cnt, value);
        end
    endtask

    task automatic test_wrap();
        int seq [4] = '{14, 15, 0, 1};
        advance_to(13);
        for (int i = 0; i < 4; i++) begin
            drive(1, seq[i], seq[i] == 15);
            checks++;
            if (err_pulse !== 1'b0 || locked !== 1'b1) begin
                failures++;
                $display("FAIL wrap_step q=%0d got err_pulse=%0b locked=%0b exp 0/1",
                         seq[i], err_pulse, locked);
            end
        end
        checks++;
        if (wrap_cnt !== 8'd1) begin
            failures++;
            $display("FAIL wrap_cnt got=%0d exp=1", wrap_cnt);
        end
    endtask

    task automatic test_error_relock();
        advance_to(5);
        drive(1, 9, 0);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL err_detect got pulse=%0b cnt=%0d locked=%0b exp 1/1/0",
                     err_pulse, err_cnt, locked);
        end
        // Recovery clock: the sample offered here must be ignored.
        drive(1, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        checks++;
        if (err_pulse !== 1'b0 || value !== 4'd9 || locked !== 1'b0 || rc_err !== 1'b0) begin
            failures++;
            $display("FAIL err_recover got pulse=%0b value=%0d locked=%0b rc_err=%0b exp 0/9/0/0",
                     err_pulse, value, locked, rc_err);
        end
        for (int q = 10; q <= 13; q++) begin
            drive(1, q, 0);
            checks++;
            if (locked !== (q == 13)) begin
                failures++;
                $display("FAIL relock q=%0d got=%0b exp=%0b", q, locked, q == 13);
            end
        end
    endtask

    task automatic test_rc();
        int e0;
        advance_to(13);
        drive(1, 14, 0);
        e0 = m_err;
        drive(1, 15, 0);   // carry missing on 15
        checks++;
        if (rc_err !== RC_CHK || err_pulse !== RC_CHK || locked !== !RC_CHK) begin
            failures++;
            $display("FAIL rc_check got rc_err=%0b pulse=%0b locked=%0b exp %0b/%0b/%0b",
                     rc_err, err_pulse, locked, RC_CHK, RC_CHK, !RC_CHK);
        end
        checks++;
        if (err_cnt !== 8'(e0 + int'(RC_CHK))) begin
            failures++;
            $display("FAIL rc_err_cnt got=%0d exp=%0d", err_cnt, e0 + int'(RC_CHK));
        end
    endtask

    task automatic test_enable();
        advance_to(3);
        drive(1, 4, 0);
        drive(0, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        drive(0, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        drive(1, 5, 0);
        checks++;
        if (locked !== 1'b1 || err_pulse !== 1'b0 || value !== 4'd5) begin
            failures++;
            $display("FAIL enable_gap got locked=%0b pulse=%0b value=%0d exp 1/0/5",
                     locked, err_pulse, value);
        end
        drive(1, 6, 0);
        drive(1, 6, 0);    // stalled counter
        checks++;
        if (err_pulse !== 1'b1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL stall_error got pulse=%0b locked=%0b exp 1/0", err_pulse, locked);
        end
    endtask

    task automatic test_random();
        int q;
        bit rc;
        bit en;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            q  = ($urandom_range(0, 4) != 0) ? (m_value + 1) % 16 : int'($urandom_range(0, 15));
            rc = ($urandom_range(0, 9) == 0) ? (q != 15) : (q == 15);
            drive(en, q, rc);
            checks++;
            if ({locked, err_pulse, rc_err, err_cnt, wrap_cnt, value} !==
                {m_locked, e_err_pulse, e_rc_err, 8'(m_err), 8'(m_wrap), 4'(m_value)}) begin
                failures++;
                $display("FAIL random cyc=%0d got lk=%0b ep=%0b rc=%0b ec=%0d wc=%0d v=%0d exp lk=%0b ep=%0b rc=%0b ec=%0d wc=%0d v=%0d",
                         i, locked, err_pulse, rc_err, err_cnt, wrap_cnt, value,
                         m_locked, e_err_pulse, e_rc_err, m_err, m_wrap, m_value);
            end
        end
    endtask

    task automatic test_reset_mid_lock_saturate();
        int sq;
        advance_to(8);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({locked, err_pulse, rc_err, err_cnt, wrap_cnt, value} !== 23'd0) begin
            failures++;
            $display("FAIL reset_mid_lock got=%h exp=0",
                     {locked, err_pulse, rc_err, err_cnt, wrap_cnt, value});
        end
        @(negedge clk);
        rst_n = 1'b1;
        // First sample after release is a fresh acquisition start.
        drive(1, 11, 0);
        checks++;
        if (value !== 4'd11 || locked !== 1'b0 || err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_first got value=%0d locked=%0b pulse=%0b exp 11/0/0",
                     value, locked, err_pulse);
        end
        for (int n = 0; n < 257; n++) begin
            advance_to(-1);
            sq = m_value;
            drive(1, sq, sq == 15);   // repeated value forces an error
            if (n >= 254) begin
                checks++;
                if (err_pulse !== 1'b1 || err_cnt !== 8'(m_err)) begin
                    failures++;
                    $display("FAIL saturate n=%0d got pulse=%0b cnt=%0d exp 1/%0d",
                             n, err_pulse, err_cnt, m_err);
                end
            end
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            failures++;
            $display("FAIL err_cnt_held got=%0d exp=255", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_wrap();
        test_error_relock();
        test_rc();
        test_enable();
        test_random();
        test_reset_mid_lock_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a wait ever stalls.
    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
